seq_onehot_decoder: RTL and testbench
=====================================

Name: seq_onehot_decoder

Overview:
- Registered, parametrised address-to-one-hot select generator: ADDR_W-bit address to NUM_OUT one-hot lines.
- Adds a valid/ready request handshake, timed strobe pulses, latched selects, and auto-scan (walking-one) modes.
- Drives register-file write enables, chip selects and scan-chain row selects.
- Output is always registered, so downstream logic sees glitch-free selects.

Parameters:
- ADDR_W, 3: address width; legal 1..8.
- NUM_OUT, 8: number of select lines; legal 2..2**ADDR_W.
- PULSE_LEN, 1: cycles each select is held in pulse and scan modes; legal 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  2  00 DECODE_PULSE, 01 DECODE_LATCH, 10 SCAN_ONCE, 11 SCAN_LOOP; sampled only at accept.
- req_valid  in  1  request strobe.
- req_ready  out  1  block can accept a request.
- req_addr  in  ADDR_W  target index (decode modes only).
- abort  in  1  cancel the current activity.
- out  out  NUM_OUT  one-hot select, or all-zero.
- cur_idx  out  ADDR_W  index of the asserted out bit; 0 when out==0.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle out-of-range pulse.

Behaviour:
- Reset (async assert, sync deassert handled externally): out=0, cur_idx=0, done=0, err=0, state IDLE, slot counter 0, so req_ready=1 once abort is low.
- States are IDLE, PULSE, LATCH, SCAN.
- req_ready = (state==IDLE or state==LATCH) and !abort.
- Accept occurs when req_valid && req_ready in cycle T. Mode and addr are captured at T. Selects appear at T+1 (latency 1).
- Invariant: out is zero or exactly one-hot in every cycle.
- DECODE_PULSE: out=1<<addr for cycles T+1..T+PULSE_LEN. done is high in cycle T+PULSE_LEN. Then out=0, state returns to IDLE, and req_ready is high from T+PULSE_LEN+1.
- DECODE_LATCH:
  - out=1<<addr from T+1, held indefinitely. done pulses at T+1. req_ready stays high.
  - A new accept replaces out at the next cycle with no zero gap. A switch to a pulse or scan mode from LATCH also takes effect next cycle.
- Out-of-range (decode modes, addr >= NUM_OUT): err pulses at T+1 and out=0 at T+1. Any latched select is cleared. State goes to IDLE. No done pulse.
- SCAN_ONCE:
  - req_addr is ignored. Index 0..NUM_OUT-1 is asserted in turn, PULSE_LEN cycles each, starting at T+1.
  - done is high in the last cycle of slot NUM_OUT-1. The next cycle has out=0 and state IDLE.
  - Total active cycles = NUM_OUT*PULSE_LEN.
- SCAN_LOOP: same as SCAN_ONCE, but wraps from NUM_OUT-1 to 0 with no gap. done pulses in the last cycle of every pass. Only abort or reset ends it.
- abort has the highest priority:
  - It forces req_ready low in the same cycle.
  - Next cycle: out=0, cur_idx=0, state IDLE, and no done or err.
  - abort together with req_valid means no accept.
- Slot counter width is $clog2(PULSE_LEN+1). Index counter wraps at NUM_OUT, not 2**ADDR_W.
- mode and req_addr changes while not accepting are ignored.
- Reset mid-operation clears everything immediately (asynchronous); no done is produced.

Decomposition:
- Package seq_decoder_pkg:
  - dec_mode_e enum (DECODE_PULSE, DECODE_LATCH, SCAN_ONCE, SCAN_LOOP).
  - dec_state_e enum (IDLE, PULSE, LATCH, SCAN).
- Sub-module onehot_decoder: purely combinational, parametrised ADDR_W to NUM_OUT one-hot decode with in-range flag. It is instantiated once, feeding the out register from the selected index (captured addr or scan index).
- FSM, slot counter and index counter live in the top.

Test Plan:
- DECODE_PULSE, defaults, addr=5 accepted at T: out=8'b0010_0000 at T+1 only; done at T+1; req_ready low at T+1, high at T+2.
- PULSE_LEN=3, DECODE_LATCH addr=2 then addr=6 two cycles later: out=0x04 from T+1; out=0x40 from the cycle after the second accept, with no zero cycle; done pulses after each accept.
- NUM_OUT=6, DECODE_LATCH addr=3, then addr=7: out=0x08; then err pulse, out=0, state IDLE, no done.
- SCAN_ONCE, NUM_OUT=4, PULSE_LEN=2:
  - out sequence 1,1,2,2,4,4,8,8 then 0.
  - done in the 8th cycle; cur_idx 0,0,1,1,2,2,3,3.
  - req_valid held high during the scan is not accepted.
- SCAN_LOOP, defaults, abort in the 11th active cycle:
  - out wraps from 0x80 to 0x01 with no gap; done at the 8th cycle.
  - After abort: out=0, no done; abort+req_valid in the same cycle gives no accept.
- Assert rst_n low mid-scan (asynchronously, between edges): out=0, done=0, err=0 immediately. After release, req_ready=1 and a DECODE_PULSE addr=0 gives out=0x01 at the next cycle.

Source files
------------

// File: rtl/seq_decoder_pkg.sv
// Shared mode and state encodings for the one-hot select generator.
package seq_decoder_pkg;

    typedef enum logic [1:0] {
        DECODE_PULSE = 2'b00,
        DECODE_LATCH = 2'b01,
        SCAN_ONCE    = 2'b10,
        SCAN_LOOP    = 2'b11
    } dec_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        LATCH = 2'b10,
        SCAN  = 2'b11
    } dec_state_e;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational index-to-one-hot decode; indices at or above NUM_OUT decode to all-zero.
module onehot_decoder #(
    parameter int ADDR_W  = 3,
    parameter int NUM_OUT = 8
) (
    input  logic [ADDR_W-1:0]  idx_i,
    output logic [NUM_OUT-1:0] onehot_o,
    output logic               in_range_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            onehot_o[i] = (32'(idx_i) == i);
        end
    end

    assign in_range_o = (32'(idx_i) < NUM_OUT);

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered address-to-one-hot select generator with pulse, latch and walking-one scan modes.
module seq_onehot_decoder
    import seq_decoder_pkg::*;
#(
    parameter int ADDR_W    = 3,
    parameter int NUM_OUT   = 8,
    parameter int PULSE_LEN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic               abort,
    output logic [NUM_OUT-1:0] out,
    output logic [ADDR_W-1:0]  cur_idx,
    output logic               done,
    output logic               err
);

    localparam int                SLOT_W     = $clog2(PULSE_LEN + 1);
    localparam logic [SLOT_W-1:0] SLOT_FIRST = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(PULSE_LEN);
    localparam logic [ADDR_W-1:0] IDX_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(NUM_OUT - 1);

    dec_state_e         state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic               loop_q, loop_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept;
    logic               scan_req;
    dec_mode_e          mode_e;
    logic [ADDR_W-1:0]  sel_idx;
    logic [NUM_OUT-1:0] sel_onehot;
    logic               sel_in_range;

    assign req_ready = ((state_q == IDLE) || (state_q == LATCH)) && !abort;
    assign accept    = req_valid && req_ready;
    assign mode_e    = dec_mode_e'(mode);
    assign scan_req  = (mode_e == SCAN_ONCE) || (mode_e == SCAN_LOOP);

    // One decoder serves both the captured address and the next scan index.
    always_comb begin
        if (accept) begin
            sel_idx = scan_req ? '0 : req_addr;
        end else if (idx_q == IDX_LAST) begin
            sel_idx = '0;
        end else begin
            sel_idx = idx_q + IDX_ONE;
        end
    end

    onehot_decoder #(
        .ADDR_W  (ADDR_W),
        .NUM_OUT (NUM_OUT)
    ) u_dec (
        .idx_i      (sel_idx),
        .onehot_o   (sel_onehot),
        .in_range_o (sel_in_range)
    );

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        idx_d   = idx_q;
        out_d   = out_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (abort) begin
            state_d = IDLE;
            slot_d  = '0;
            idx_d   = '0;
            out_d   = '0;
            loop_d  = 1'b0;
        end else if (accept) begin
            slot_d = SLOT_FIRST;
            idx_d  = sel_idx;
            out_d  = sel_onehot;
            loop_d = (mode_e == SCAN_LOOP);
            if (scan_req) begin
                state_d = SCAN;
            end else if (!sel_in_range) begin
                state_d = IDLE;
                slot_d  = '0;
                idx_d   = '0;
                out_d   = '0;
                err_d   = 1'b1;
            end else if (mode_e == DECODE_PULSE) begin
                state_d = PULSE;
                done_d  = (SLOT_FIRST == SLOT_LAST);
            end else begin
                state_d = LATCH;
                done_d  = 1'b1;
            end
        end else begin
            case (state_q)
                PULSE: begin
                    if (slot_q == SLOT_LAST) begin
                        state_d = IDLE;
                        slot_d  = '0;
                        idx_d   = '0;
                        out_d   = '0;
                    end else begin
                        slot_d = slot_q + SLOT_FIRST;
                        done_d = ((slot_q + SLOT_FIRST) == SLOT_LAST);
                    end
                end
                SCAN: begin
                    if (slot_q != SLOT_LAST) begin
                        slot_d = slot_q + SLOT_FIRST;
                        done_d = ((slot_q + SLOT_FIRST) == SLOT_LAST) && (idx_q == IDX_LAST);
                    end else if ((idx_q == IDX_LAST) && !loop_q) begin
                        state_d = IDLE;
                        slot_d  = '0;
                        idx_d   = '0;
                        out_d   = '0;
                        loop_d  = 1'b0;
                    end else begin
                        slot_d = SLOT_FIRST;
                        idx_d  = sel_idx;
                        out_d  = sel_onehot;
                        done_d = (SLOT_FIRST == SLOT_LAST) && (sel_idx == IDX_LAST);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign out     = out_q;
    assign cur_idx = idx_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Directed bench: four configurations share one stimulus bus; each test checks the instance it targets.
module tb_seq_onehot_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       req_valid;
    logic [2:0] req_addr;
    logic       abort;

    logic       rdy_a, rdy_b, rdy_c, rdy_d;
    logic [7:0] out_a, out_b;
    logic [5:0] out_c;
    logic [3:0] out_d;
    logic [2:0] idx_a, idx_b, idx_c, idx_d;
    logic       done_a, done_b, done_c, done_d;
    logic       err_a, err_b, err_c, err_d;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // A: defaults, B: PULSE_LEN=3, C: NUM_OUT=6, D: NUM_OUT=4 PULSE_LEN=2
    seq_onehot_decoder #(.ADDR_W(3), .NUM_OUT(8), .PULSE_LEN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode), .req_valid(req_valid), .req_ready(rdy_a),
        .req_addr(req_addr), .abort(abort), .out(out_a), .cur_idx(idx_a), .done(done_a), .err(err_a));
    seq_onehot_decoder #(.ADDR_W(3), .NUM_OUT(8), .PULSE_LEN(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode), .req_valid(req_valid), .req_ready(rdy_b),
        .req_addr(req_addr), .abort(abort), .out(out_b), .cur_idx(idx_b), .done(done_b), .err(err_b));
    seq_onehot_decoder #(.ADDR_W(3), .NUM_OUT(6), .PULSE_LEN(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .mode(mode), .req_valid(req_valid), .req_ready(rdy_c),
        .req_addr(req_addr), .abort(abort), .out(out_c), .cur_idx(idx_c), .done(done_c), .err(err_c));
    seq_onehot_decoder #(.ADDR_W(3), .NUM_OUT(4), .PULSE_LEN(2)) dut_d (
        .clk(clk), .rst_n(rst_n), .mode(mode), .req_valid(req_valid), .req_ready(rdy_d),
        .req_addr(req_addr), .abort(abort), .out(out_d), .cur_idx(idx_d), .done(done_d), .err(err_d));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        req_valid = 1'b0;
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 2'b00;
        req_valid = 1'b0;
        req_addr  = 3'd0;
        abort     = 1'b0;
        #1;
        chk("rst_out", 32'(out_a), 32'h0);
        chk("rst_idx", 32'(idx_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        chk("rst_err", 32'(err_a), 32'h0);
        chk("rst_ready", 32'(rdy_a), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pulse, PULSE_LEN=1, addr 5
        mode = 2'b00; req_addr = 3'd5; req_valid = 1'b1;
        #1;
        chk("pulse_ready_T", 32'(rdy_a), 32'h1);
        tick();
        req_valid = 1'b0;
        chk("pulse_out_T1", 32'(out_a), 32'h20);
        chk("pulse_idx_T1", 32'(idx_a), 32'h5);
        chk("pulse_done_T1", 32'(done_a), 32'h1);
        chk("pulse_ready_T1", 32'(rdy_a), 32'h0);
        tick();
        chk("pulse_out_T2", 32'(out_a), 32'h0);
        chk("pulse_done_T2", 32'(done_a), 32'h0);
        chk("pulse_ready_T2", 32'(rdy_a), 32'h1);

        // Latch replace on PULSE_LEN=3 instance
        clear_all();
        mode = 2'b01; req_addr = 3'd2; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("latch_out_a1", 32'(out_b), 32'h04);
        chk("latch_done_a1", 32'(done_b), 32'h1);
        chk("latch_ready_a1", 32'(rdy_b), 32'h1);
        tick();
        chk("latch_hold", 32'(out_b), 32'h04);
        chk("latch_done_hold", 32'(done_b), 32'h0);
        req_addr = 3'd6; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("latch_out_a2", 32'(out_b), 32'h40);
        chk("latch_done_a2", 32'(done_b), 32'h1);
        tick();
        chk("latch_hold2", 32'(out_b), 32'h40);
        chk("latch_done_hold2", 32'(done_b), 32'h0);

        // Out of range on NUM_OUT=6
        clear_all();
        mode = 2'b01; req_addr = 3'd3; req_valid = 1'b1;
        tick();
        chk("range_out_ok", 32'(out_c), 32'h08);
        req_addr = 3'd7;
        tick();
        req_valid = 1'b0;
        chk("range_err", 32'(err_c), 32'h1);
        chk("range_out0", 32'(out_c), 32'h0);
        chk("range_idx0", 32'(idx_c), 32'h0);
        chk("range_nodone", 32'(done_c), 32'h0);
        chk("range_idle_ready", 32'(rdy_c), 32'h1);
        tick();
        chk("range_err_gone", 32'(err_c), 32'h0);
        chk("range_stays0", 32'(out_c), 32'h0);

        // Scan once, NUM_OUT=4, PULSE_LEN=2, req_valid held high
        clear_all();
        mode = 2'b10; req_valid = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("scan1_out", 32'(out_d), 32'(1) << (k / 2));
            chk("scan1_idx", 32'(idx_d), 32'(k / 2));
            chk("scan1_done", 32'(done_d), (k == 7) ? 32'h1 : 32'h0);
            chk("scan1_ready", 32'(rdy_d), 32'h0);
            if (k == 7) req_valid = 1'b0;
            tick();
        end
        chk("scan1_end_out", 32'(out_d), 32'h0);
        chk("scan1_end_done", 32'(done_d), 32'h0);
        chk("scan1_end_ready", 32'(rdy_d), 32'h1);

        // Scan loop on defaults, abort in the 11th active cycle
        clear_all();
        mode = 2'b11; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk("loop_out", 32'(out_a), 32'(1) << ((k - 1) % 8));
            chk("loop_done", 32'(done_a), (k == 8) ? 32'h1 : 32'h0);
            tick();
        end
        chk("loop_out_11", 32'(out_a), 32'h04);
        abort = 1'b1; req_valid = 1'b1; mode = 2'b00; req_addr = 3'd1;
        #1;
        chk("abort_ready", 32'(rdy_a), 32'h0);
        tick();
        chk("abort_out", 32'(out_a), 32'h0);
        chk("abort_idx", 32'(idx_a), 32'h0);
        chk("abort_done", 32'(done_a), 32'h0);
        abort = 1'b0; req_valid = 1'b0;
        #1;
        chk("abort_ready_after", 32'(rdy_a), 32'h1);
        tick();
        chk("abort_no_accept", 32'(out_a), 32'h0);

        // Asynchronous reset during the done cycle of a scan
        clear_all();
        mode = 2'b10; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (7) tick();
        chk("pre_rst_out", 32'(out_a), 32'h80);
        chk("pre_rst_done", 32'(done_a), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(out_a), 32'h0);
        chk("async_rst_done", 32'(done_a), 32'h0);
        chk("async_rst_err", 32'(err_a), 32'h0);
        chk("async_rst_idx", 32'(idx_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(rdy_a), 32'h1);
        mode = 2'b00; req_addr = 3'd0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("post_rst_out", 32'(out_a), 32'h01);
        chk("post_rst_done", 32'(done_a), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
